// File: rtl/sdio_timeout_sched.sv
// Shares one SDIO timeout timer between the CMD, BSY and RD wait agents and attributes expiries.
// Optional SDIO_TIMEOUT_RETRY_EN: re-arm the timer RETRY_MAX times before flagging an expiry.
module sdio_timeout_sched #(
  parameter int unsigned RETRY_MAX = 2
) (
  input  logic        sd_clk,
  input  logic        rst,
  input  logic [2:0]  req,
  input  logic [2:0]  done,
  input  logic [23:0] cfg_sel,
  input  logic [2:0]  clr_flag,
  input  logic        timeout_event,
  output logic        timeout_cnt_en,
  output logic [7:0]  timeout_cnt_sel,
  output logic [2:0]  grant,
  output logic [2:0]  timeout_flag,
  output logic        timeout_irq
);

  localparam int unsigned N_AG  = 3;
  localparam int unsigned SEL_W = 8;
  localparam int unsigned RC_W  = 2;

`ifdef SDIO_TIMEOUT_RETRY_EN
  localparam logic [RC_W-1:0] RETRY_LIM = RC_W'(RETRY_MAX);
`else
  // Zero limit makes the first expiry flag; RETRY_MAX has no effect here.
  localparam logic [RC_W-1:0] RETRY_LIM = RC_W'(RETRY_MAX * 0);
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  state_t             r_state, w_state;
  logic [N_AG-1:0]    r_grant, w_grant;
  logic [SEL_W-1:0]   r_sel, w_sel;
  logic               r_en, w_en;
  logic [N_AG-1:0]    r_flag, w_flag;
  logic               r_irq, w_irq;
  logic [RC_W-1:0]    r_retry, w_retry;

  logic [N_AG-1:0]    w_elig;
  logic [N_AG-1:0]    w_pick;
  logic [SEL_W-1:0]   w_pick_sel;
  logic               w_own_done;
  logic               w_own_req;
  logic               w_retry_ok;

  // Fixed-priority pick among unflagged requesters: CMD > BSY > RD.
  always_comb begin
    w_elig     = req & ~r_flag;
    w_pick     = '0;
    w_pick_sel = '0;
    if (w_elig[0]) begin
      w_pick     = 3'b001;
      w_pick_sel = cfg_sel[7:0];
    end else if (w_elig[1]) begin
      w_pick     = 3'b010;
      w_pick_sel = cfg_sel[15:8];
    end else if (w_elig[2]) begin
      w_pick     = 3'b100;
      w_pick_sel = cfg_sel[23:16];
    end
  end

  assign w_own_done = |(done & r_grant);
  assign w_own_req  = |(req & r_grant);
  assign w_retry_ok = (r_retry != RETRY_LIM);

  always_comb begin
    w_state = r_state;
    w_grant = r_grant;
    w_sel   = r_sel;
    w_en    = 1'b0;
    w_irq   = 1'b0;
    w_retry = r_retry;
    w_flag  = r_flag & ~clr_flag;
    case (r_state)
      S_IDLE: begin
        if (|w_elig) begin
          w_grant = w_pick;
          w_sel   = w_pick_sel;
          w_en    = 1'b1;
          w_retry = '0;
          w_state = S_RUN;
        end
      end
      S_RUN: begin
        // Completion beats expiry; requests of other agents are ignored.
        if (w_own_done || !w_own_req) begin
          w_grant = '0;
          w_state = S_GAP;
        end else if (timeout_event) begin
          w_state = S_GAP;
          if (w_retry_ok) begin
            w_retry = r_retry + RC_W'(1);
          end else begin
            w_flag  = w_flag | r_grant;
            w_irq   = 1'b1;
            w_grant = '0;
          end
        end else begin
          w_en = 1'b1;
        end
      end
      S_GAP: begin
        // A grant still held here is a retry re-arm for the same agent.
        if ((r_grant != '0) && w_own_req && !w_own_done) begin
          w_en    = 1'b1;
          w_state = S_RUN;
        end else begin
          w_grant = '0;
          w_state = S_IDLE;
        end
      end
      default: begin
        w_grant = '0;
        w_state = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge sd_clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_grant <= '0;
      r_sel   <= '0;
      r_en    <= 1'b0;
      r_flag  <= '0;
      r_irq   <= 1'b0;
      r_retry <= '0;
    end else begin
      r_state <= w_state;
      r_grant <= w_grant;
      r_sel   <= w_sel;
      r_en    <= w_en;
      r_flag  <= w_flag;
      r_irq   <= w_irq;
      r_retry <= w_retry;
    end
  end

  assign timeout_cnt_en  = r_en;
  assign timeout_cnt_sel = r_sel;
  assign grant           = r_grant;
  assign timeout_flag    = r_flag;
  assign timeout_irq     = r_irq;

endmodule

// File: doc/sdio_timeout_sched.md
Name: sdio_timeout_sched

Overview:
- Shares the single SDIO timeout timer between three waiting agents: command-response wait (CMD), write busy wait (BSY) and read-data wait (RD).
- Arbitrates the agents' requests and latches the granted agent's timeout select.
- Drives the timer's enable and select inputs and attributes each expiry to the agent that owned the timer.
- Sits between the SDIO command/data engines and the timer, in the sd_clk domain.

Parameters:
- RETRY_MAX, 2, number of extra re-arms before an expiry is flagged. Used only with SDIO_TIMEOUT_RETRY_EN.

Ports:
- sd_clk  input  1  SD clock; all logic is on the rising edge.
- rst  input  1  asynchronous active-high reset.
- req  input  3  level wait requests: bit0=CMD, bit1=BSY, bit2=RD.
- done  input  3  per-agent one-cycle pulse: the awaited condition arrived.
- cfg_sel  input  24  per-agent timeout select: [7:0]=CMD, [15:8]=BSY, [23:16]=RD.
- clr_flag  input  3  one-cycle pulse per bit; clears the matching timeout_flag bit.
- timeout_event  input  1  expiry pulse from the timer.
- timeout_cnt_en  output  1  timer enable; the timer clears its count while this is low.
- timeout_cnt_sel  output  8  timer select, latched at grant.
- grant  output  3  one-hot owner of the timer; all zero when idle.
- timeout_flag  output  3  sticky per-agent expiry flags.
- timeout_irq  output  1  one-cycle pulse when any flag is set.

Behaviour:
- Reset values:
  - State=IDLE.
  - All outputs 0.
  - Retry counter 0.
- States: IDLE, RUN, GAP.
- IDLE:
  - timeout_cnt_en=0.
  - Eligible agents are those with req high and timeout_flag low.
  - Fixed priority CMD > BSY > RD.
  - If any agent is eligible at edge t: grant, timeout_cnt_sel (the granted agent's cfg_sel slice) and timeout_cnt_en=1 all appear at t+1. State goes to RUN.
- RUN:
  - timeout_cnt_en=1; grant and timeout_cnt_sel are held.
  - cfg_sel changes during RUN are ignored until the next grant.
  - No preemption; higher-priority requests wait for GAP.
- Exits from RUN (all go to GAP; grant=0 and timeout_cnt_en=0 in the next cycle):
  - done[granted] high: normal completion, no flag.
  - req[granted] low: abort, no flag.
  - timeout_event high (expiry): set timeout_flag[granted] and pulse timeout_irq for one cycle.
  - done and timeout_event in the same cycle: done wins, no flag, no irq.
  - done/req bits of non-granted agents are ignored.
- GAP:
  - Lasts exactly one cycle with timeout_cnt_en=0, which guarantees the timer count returns to 0.
  - Then goes to IDLE; re-arbitration happens in IDLE, so back-to-back grants are separated by 2 cycles with enable low.
- Timer arithmetic:
  - Timer limit = {sel, 2'b11, 16'hffff}.
  - Expiry fires when the count reaches limit with bit0 cleared: K = sel*2^18 + 2^18 - 2 enabled cycles after the first enable cycle.
  - For sel=0, K=262142.
- Flags:
  - A flagged agent is masked from arbitration until cleared.
  - clr_flag and a flag set to the same bit in the same cycle: set wins.
- Reset mid-operation: immediate return to IDLE; all outputs and flags are 0.

Optional Feature:
- Macro: SDIO_TIMEOUT_RETRY_EN.
- Defined:
  - A 2-bit retry counter is cleared at each grant.
  - On expiry with counter < RETRY_MAX: increment the counter, go to GAP, then re-enter RUN for the same agent without arbitration. grant stays held; timeout_cnt_en is low for one cycle. No flag, no irq.
  - On expiry with counter == RETRY_MAX: flag and irq as normal.
  - done or abort during any retry ends the wait normally.
- Undefined: the first expiry flags; RETRY_MAX is unused.

Test Plan:
- Reset applied mid-RUN (BSY granted) -> next cycle all outputs 0, state IDLE, BSY flag 0.
- req=3'b101 in IDLE, CMD cfg_sel=8'h00, RD cfg_sel=8'h05 -> grant=001 with sel=00 one cycle later; after CMD done, one GAP cycle with enable 0, then grant=100 with sel=05 after IDLE.
- req[1] held, sel=0, timer model attached, no done -> timeout_irq pulses once 262142 cycles after enable rises; timeout_flag=010; BSY is not re-granted while req stays high. clr_flag=010 -> BSY is re-granted.
- CMD granted, done[0] and timeout_event in the same cycle -> no flag, no irq, next cycle grant=0 and enable 0.
- CMD granted, req[0] dropped -> abort, no flag; cfg_sel changed mid-RUN -> timeout_cnt_sel unchanged.
- With SDIO_TIMEOUT_RETRY_EN, RETRY_MAX=2, sel=0 -> three expiries with grant held and a one-cycle enable-low gap between them; flag and irq appear only on the third expiry.
